dmem_sized: RTL and testbench
=============================

Name: dmem_sized

Overview:
- Next-generation data memory for the core's MEM stage.
- Byte-addressed with RISC-V load/store sizes: byte, half, word, and double when DATA_WIDTH=64.
- Byte-lane writes, sign/zero extension on loads, misalignment error reporting.
- Valid/ready request port, pipelined read latency set by parameter, hardware clear FSM after reset (replaces an array-wide reset).

Parameters:
- DATA_WIDTH, 32: word width; legal values 32 or 64.
- DMEM_SZ_IN_KB, 1: capacity in KiB.
- READ_LATENCY, 1: cycles from request acceptance to response; legal range 1..4.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = contents undefined, ready immediately.
- ADDR_WIDTH (localparam), $clog2(DMEM_SZ_IN_KB*1024): byte address width.
- DEPTH (localparam), DMEM_SZ_IN_KB*1024/(DATA_WIDTH/8): number of words.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 double
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- rsp_valid  out  1  response present, one cycle pulse per request
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal size
- init_busy  out  1  clear FSM running

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=CLEAR_ON_RESET. All pipeline valid bits are cleared. The RAM array itself is not reset.
- FSM has two states, INIT and RUN. Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
- INIT:
  - Counter clr_idx runs 0..DEPTH-1 and writes one zero word per cycle.
  - After the write to DEPTH-1 the FSM moves to RUN: init_busy=0 and req_ready=1 from the next cycle.
  - Total INIT duration is exactly DEPTH cycles. req_ready=0 throughout, and requests are ignored.
- RUN: req_ready=1 constantly. The block never back-pressures, and the response port has no ready.
- Acceptance is req_valid && req_ready. Fully pipelined: one request per cycle.
- Word index = req_addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]. Lane offset = the low address bits.
- Error check:
  - Half requires addr[0]=0. Word requires addr[1:0]=0. Double requires addr[2:0]=0.
  - size=3 with DATA_WIDTH=32 is illegal.
  - On error: stores do not modify memory; loads return rsp_rdata=0. Both report rsp_err=1.
- Stores:
  - Data is replicated across lanes. Byte enables cover size bytes starting at the lane offset.
  - Memory updates at the acceptance clock edge. Bytes outside the enables are unchanged.
- Loads:
  - Word is read at the acceptance edge, then the selected bytes are shifted down.
  - Extension per req_unsigned up to DATA_WIDTH. Full-width loads are unaffected by req_unsigned.
- Latency: a request accepted in cycle t gives rsp_valid=1 in cycle t+READ_LATENCY, for both loads and stores, so order is preserved.
- Pipeline registers carry valid, offset, size, unsigned, err and write through READ_LATENCY stages.
- Read-after-write: a store accepted in cycle t is visible to a load accepted in cycle t+1 or later. There is no same-cycle conflict, since the port takes one request per cycle.
- Back-to-back responses: consecutive accepts produce consecutive rsp_valid cycles.
- Addresses cannot go out of range: ADDR_WIDTH spans exactly the memory.
- Reset mid-operation (including mid-INIT):
  - In-flight responses are dropped: rsp_valid goes to 0 immediately.
  - The FSM re-enters INIT and clr_idx restarts at 0.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, DMEM_SZ_IN_KB=1, DATA_WIDTH=32 -> init_busy=1 for exactly 256 cycles, then req_ready=1. A word load from 0x3FC returns 0x00000000, err=0.
2. Store word 0xDEADBEEF at 0x10, then byte 0x55 at 0x11 -> load word 0x10 returns 0xDEAD55EF. Load byte signed 0x13 returns 0xFFFFFFDE. Load half unsigned 0x12 returns 0x0000DEAD.
3. READ_LATENCY=3: loads accepted in cycles 10, 11, 12 -> rsp_valid high in cycles 13, 14, 15 with data in request order. Store-then-load on consecutive cycles returns the new data.
4. Store half at 0x21 and word at 0x22 -> both rsp_err=1, and memory at 0x20 is unchanged. Size 3 with DATA_WIDTH=32 -> rsp_err=1, rdata=0.
5. DATA_WIDTH=64: store double 0x0123456789ABCDEF at 0x8 -> load word signed 0xC returns 0x0000000001234567. Load byte signed 0x8 returns 0xFFFFFFFFFFFFFFEF.
6. Assert arst_n=0 with two loads in flight and again at clr_idx=100 -> rsp_valid=0 immediately, no stale responses appear, and INIT restarts with the full 256-cycle clear.

Source files
------------

// File: rtl/dmem_sized.sv
// Byte-addressed data memory for the MEM stage: sized loads/stores with lane enables,
// sign/zero extension, misalignment errors, a fixed-latency pipeline and a post-reset clear FSM.
module dmem_sized #(
   parameter  int DATA_WIDTH     = 32,
   parameter  int DMEM_SZ_IN_KB  = 1,
   parameter  int READ_LATENCY   = 1,
   parameter  bit CLEAR_ON_RESET = 1'b1,
   localparam int ADDR_WIDTH     = $clog2(DMEM_SZ_IN_KB*1024),
   localparam int DEPTH          = DMEM_SZ_IN_KB*1024/(DATA_WIDTH/8)
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  init_busy
);

   localparam int NB    = DATA_WIDTH/8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = ADDR_WIDTH - OFF_W;
   localparam int LAST  = READ_LATENCY - 1;

   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
   logic             ready_q;
   logic             clr_we;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  acc;
   logic                  req_err;
   logic [IDX_W-1:0]      widx;
   logic [OFF_W-1:0]      off;
   logic [NB-1:0]         be;
   logic [DATA_WIDTH-1:0] wrep;

   logic [READ_LATENCY-1:0] vld_q, wr_q, err_q, uns_q;
   logic [1:0]              size_q [READ_LATENCY];
   logic [OFF_W-1:0]        off_q  [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   rd_q   [READ_LATENCY];

   function automatic logic size_err(input logic [1:0] size, input logic [2:0] low);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return low[0];
         2'd2:    return |low[1:0];
         default: return (DATA_WIDTH == 32) || (|low[2:0]);
      endcase
   endfunction

   function automatic logic [NB-1:0] byte_en(input logic [1:0] size, input logic [OFF_W-1:0] o);
      logic [7:0]    m8;
      logic [NB-1:0] m;
      case (size)
         2'd0:    m8 = 8'h01;
         2'd1:    m8 = 8'h03;
         2'd2:    m8 = 8'h0F;
         default: m8 = 8'hFF;
      endcase
      m = NB'(m8);
      return m << o;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] replicate(input logic [1:0] size,
                                                       input logic [DATA_WIDTH-1:0] wd);
      case (size)
         2'd0:    return {NB{wd[7:0]}};
         2'd1:    return {(NB/2){wd[15:0]}};
         2'd2:    return {(NB/4){wd[31:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] raw,
                                                    input logic [OFF_W-1:0] o,
                                                    input logic [1:0] size, input logic uns);
      logic [DATA_WIDTH-1:0] s;
      s = raw >> {o, 3'b000};
      case (size)
         2'd0:    return uns ? DATA_WIDTH'(s[7:0])  : DATA_WIDTH'($signed(s[7:0]));
         2'd1:    return uns ? DATA_WIDTH'(s[15:0]) : DATA_WIDTH'($signed(s[15:0]));
         2'd2:    return uns ? DATA_WIDTH'(s[31:0]) : DATA_WIDTH'($signed(s[31:0]));
         default: return s;
      endcase
   endfunction

   // Clear FSM: state register, next-state logic, outputs
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= CLEAR_ON_RESET ? S_INIT : S_RUN;
         clr_idx_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ready_q   <= (state_d == S_RUN);
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (state_q == S_INIT) begin
         clr_idx_d = clr_idx_q + IDX_W'(1);
         if (clr_idx_q == IDX_W'(DEPTH-1)) state_d = S_RUN;
      end
   end

   always_comb begin
      clr_we    = (state_q == S_INIT);
      init_busy = clr_we;
      req_ready = ready_q;
   end

   assign acc     = req_valid && ready_q;
   assign req_err = size_err(req_size, req_addr[2:0]);
   assign widx    = req_addr[ADDR_WIDTH-1:OFF_W];
   assign off     = req_addr[OFF_W-1:0];
   assign be      = byte_en(req_size, off);
   assign wrep    = replicate(req_size, req_wdata);

   // Array has no reset; the clear FSM owns the write port until RUN
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_idx_q] <= '0;
      end else if (acc && req_write && !req_err) begin
         for (int b = 0; b < NB; b++)
            if (be[b]) mem[widx][b*8 +: 8] <= wrep[b*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= acc;
         for (int i = 1; i < READ_LATENCY; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      rd_q[0]   <= mem[widx];
      off_q[0]  <= off;
      size_q[0] <= req_size;
      uns_q[0]  <= req_unsigned;
      err_q[0]  <= req_err;
      wr_q[0]   <= req_write;
      for (int i = 1; i < READ_LATENCY; i++) begin
         rd_q[i]   <= rd_q[i-1];
         off_q[i]  <= off_q[i-1];
         size_q[i] <= size_q[i-1];
         uns_q[i]  <= uns_q[i-1];
         err_q[i]  <= err_q[i-1];
         wr_q[i]   <= wr_q[i-1];
      end
   end

   assign rsp_valid = vld_q[LAST];
   assign rsp_err   = vld_q[LAST] && err_q[LAST];
   assign rsp_rdata = (vld_q[LAST] && !wr_q[LAST] && !err_q[LAST])
                      ? extend(rd_q[LAST], off_q[LAST], size_q[LAST], uns_q[LAST]) : '0;

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: a 32-bit/latency-3 instance and a 64-bit/latency-1
// instance share one request stream; each step checks the instance it targets.
module tb_dmem_sized;

   logic        clk;
   logic        arst_n;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [9:0]  req_addr;
   logic [63:0] req_wdata;

   logic        a_ready, a_vld, a_err, a_busy;
   logic [31:0] a_rdata;
   logic        b_ready, b_vld, b_err, b_busy;
   logic [63:0] b_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   dmem_sized #(.DATA_WIDTH(32), .DMEM_SZ_IN_KB(1), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b1)) u_a (
      .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_ready(a_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .rsp_valid(a_vld),
      .rsp_rdata(a_rdata), .rsp_err(a_err), .init_busy(a_busy));

   dmem_sized #(.DATA_WIDTH(64), .DMEM_SZ_IN_KB(1), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_b (
      .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_ready(b_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_vld),
      .rsp_rdata(b_rdata), .rsp_err(b_err), .init_busy(b_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                        input logic [9:0] addr, input logic [63:0] wd);
      req_valid    = 1'b1;
      req_write    = w;
      req_size     = sz;
      req_unsigned = u;
      req_addr     = addr;
      req_wdata    = wd;
   endtask

   task automatic chk_a(input string tag, input logic [31:0] exp_d, input logic exp_e);
      chk({tag, ".vld"}, 64'(a_vld), 64'd1);
      chk({tag, ".data"}, 64'(a_rdata), 64'(exp_d));
      chk({tag, ".err"}, 64'(a_err), 64'(exp_e));
   endtask

   task automatic chk_b(input string tag, input logic [63:0] exp_d, input logic exp_e);
      chk({tag, ".vld"}, 64'(b_vld), 64'd1);
      chk({tag, ".data"}, b_rdata, exp_d);
      chk({tag, ".err"}, 64'(b_err), 64'(exp_e));
   endtask

   // One isolated request; waits the target instance's latency then checks its response
   task automatic xact(input bit on64, input logic w, input logic [1:0] sz, input logic u,
                       input logic [9:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_d, input logic exp_e, input string tag);
      drive(w, sz, u, addr, wd);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (on64) begin
         chk_b(tag, exp_d, exp_e);
      end else begin
         repeat (2) begin @(posedge clk); #1; end
         chk_a(tag, exp_d[31:0], exp_e);
      end
   endtask

   task automatic wait_init(output int cnt, output int c64, output bit early, output bit stale);
      cnt = 0; c64 = 0; early = 1'b0; stale = 1'b0;
      while ((a_busy || b_busy) && cnt < 1000) begin
         @(posedge clk); #1;
         cnt++;
         if (a_busy && a_ready) early = 1'b1;
         if (a_vld || b_vld) stale = 1'b1;
         if (!b_busy && c64 == 0) c64 = cnt;
         if (!a_busy) break;
      end
   endtask

   int cnt, c64;
   bit early, stale;

   initial begin
      arst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;

      // Reset values and clear duration
      #12;
      chk("rst.ready", 64'(a_ready), 64'd0);
      chk("rst.vld", 64'(a_vld), 64'd0);
      chk("rst.rdata", 64'(a_rdata), 64'd0);
      chk("rst.err", 64'(a_err), 64'd0);
      chk("rst.busy", 64'(a_busy), 64'd1);
      chk("rst.busy64", 64'(b_busy), 64'd1);
      @(negedge clk);
      arst_n = 1'b1;
      wait_init(cnt, c64, early, stale);
      chk("init.cycles", 64'(cnt), 64'd256);
      chk("init.cycles64", 64'(c64), 64'd128);
      chk("init.ready_early", 64'(early), 64'd0);
      chk("init.ready", 64'(a_ready), 64'd1);
      chk("init.ready64", 64'(b_ready), 64'd1);
      xact(1'b0, 1'b0, 2'd2, 1'b0, 10'h3FC, 64'h0, 64'h0, 1'b0, "ld_top");

      // Word store, byte overwrite, extension
      xact(1'b0, 1'b1, 2'd2, 1'b0, 10'h010, 64'hDEADBEEF, 64'h0, 1'b0, "st_w10");
      xact(1'b0, 1'b1, 2'd0, 1'b0, 10'h011, 64'h55, 64'h0, 1'b0, "st_b11");
      xact(1'b0, 1'b0, 2'd2, 1'b0, 10'h010, 64'h0, 64'hDEAD55EF, 1'b0, "ld_w10");
      xact(1'b0, 1'b0, 2'd0, 1'b0, 10'h013, 64'h0, 64'hFFFFFFDE, 1'b0, "ld_bs13");
      xact(1'b0, 1'b0, 2'd1, 1'b1, 10'h012, 64'h0, 64'h0000DEAD, 1'b0, "ld_hu12");
      xact(1'b0, 1'b0, 2'd1, 1'b0, 10'h012, 64'h0, 64'hFFFFDEAD, 1'b0, "ld_hs12");
      xact(1'b0, 1'b0, 2'd0, 1'b1, 10'h011, 64'h0, 64'h00000055, 1'b0, "ld_bu11");

      // Back-to-back loads through the 3-deep pipeline
      drive(1'b0, 2'd2, 1'b0, 10'h010, 64'h0);
      @(posedge clk); #1;
      drive(1'b0, 2'd1, 1'b1, 10'h012, 64'h0);
      @(posedge clk); #1;
      drive(1'b0, 2'd0, 1'b0, 10'h013, 64'h0);
      chk("pipe.early", 64'(a_vld), 64'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk_a("pipe0", 32'hDEAD55EF, 1'b0);
      @(posedge clk); #1;
      chk_a("pipe1", 32'h0000DEAD, 1'b0);
      @(posedge clk); #1;
      chk_a("pipe2", 32'hFFFFFFDE, 1'b0);
      @(posedge clk); #1;
      chk("pipe.end", 64'(a_vld), 64'd0);

      // Store then load on consecutive cycles
      drive(1'b1, 2'd2, 1'b0, 10'h040, 64'h12345678);
      @(posedge clk); #1;
      drive(1'b0, 2'd2, 1'b0, 10'h040, 64'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk_a("raw.st", 32'h0, 1'b0);
      @(posedge clk); #1;
      chk_a("raw.ld", 32'h12345678, 1'b0);

      // Misalignment and illegal size
      xact(1'b0, 1'b1, 2'd2, 1'b0, 10'h020, 64'hCAFEF00D, 64'h0, 1'b0, "st_w20");
      xact(1'b0, 1'b1, 2'd1, 1'b0, 10'h021, 64'h1111, 64'h0, 1'b1, "st_h21");
      xact(1'b0, 1'b1, 2'd2, 1'b0, 10'h022, 64'h22222222, 64'h0, 1'b1, "st_w22");
      xact(1'b0, 1'b0, 2'd2, 1'b0, 10'h020, 64'h0, 64'hCAFEF00D, 1'b0, "ld_w20");
      xact(1'b0, 1'b0, 2'd3, 1'b0, 10'h020, 64'h0, 64'h0, 1'b1, "ld_d32");
      xact(1'b0, 1'b0, 2'd1, 1'b0, 10'h023, 64'h0, 64'h0, 1'b1, "ld_h23");

      // 64-bit instance
      xact(1'b1, 1'b1, 2'd3, 1'b0, 10'h008, 64'h0123456789ABCDEF, 64'h0, 1'b0, "st_d08");
      xact(1'b1, 1'b0, 2'd2, 1'b0, 10'h00C, 64'h0, 64'h0000000001234567, 1'b0, "ld_ws0C");
      xact(1'b1, 1'b0, 2'd0, 1'b0, 10'h008, 64'h0, 64'hFFFFFFFFFFFFFFEF, 1'b0, "ld_bs08");
      xact(1'b1, 1'b0, 2'd2, 1'b0, 10'h008, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, "ld_ws08");
      xact(1'b1, 1'b0, 2'd2, 1'b1, 10'h008, 64'h0, 64'h0000000089ABCDEF, 1'b0, "ld_wu08");
      xact(1'b1, 1'b0, 2'd1, 1'b0, 10'h00A, 64'h0, 64'hFFFFFFFFFFFF89AB, 1'b0, "ld_hs0A");
      xact(1'b1, 1'b1, 2'd0, 1'b0, 10'h00F, 64'h7A, 64'h0, 1'b0, "st_b0F");
      xact(1'b1, 1'b0, 2'd3, 1'b1, 10'h008, 64'h0, 64'h7A23456789ABCDEF, 1'b0, "ld_d08");
      xact(1'b1, 1'b0, 2'd3, 1'b0, 10'h004, 64'h0, 64'h0, 1'b1, "ld_d04");

      // Reset with two loads in flight
      drive(1'b0, 2'd2, 1'b0, 10'h010, 64'h0);
      @(posedge clk); #1;
      drive(1'b0, 2'd2, 1'b0, 10'h014, 64'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      arst_n = 1'b0;
      #1;
      chk("rst2.vld", 64'(a_vld), 64'd0);
      chk("rst2.vld64", 64'(b_vld), 64'd0);
      chk("rst2.busy", 64'(a_busy), 64'd1);
      chk("rst2.ready", 64'(a_ready), 64'd0);
      @(posedge clk); #1;
      chk("rst2.stale", 64'(a_vld), 64'd0);
      arst_n = 1'b1;
      stale = 1'b0;
      repeat (100) begin
         @(posedge clk); #1;
         if (a_vld || b_vld) stale = 1'b1;
      end
      chk("rst2.no_stale", 64'(stale), 64'd0);
      chk("rst2.busy100", 64'(a_busy), 64'd1);

      // Reset again mid-clear at index 100
      arst_n = 1'b0;
      #2;
      chk("rst3.busy", 64'(a_busy), 64'd1);
      @(posedge clk); #1;
      arst_n = 1'b1;
      wait_init(cnt, c64, early, stale);
      chk("rst3.cycles", 64'(cnt), 64'd256);
      chk("rst3.cycles64", 64'(c64), 64'd128);
      chk("rst3.stale", 64'(stale), 64'd0);
      chk("rst3.ready", 64'(a_ready), 64'd1);
      xact(1'b0, 1'b0, 2'd2, 1'b0, 10'h010, 64'h0, 64'h0, 1'b0, "clr_w10");
      xact(1'b1, 1'b0, 2'd3, 1'b0, 10'h008, 64'h0, 64'h0, 1'b0, "clr_d08");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
